// File: rtl/mu0_ctrl_seq.sv
// MU0 multi-cycle fetch/execute control sequencer with a req/ready memory handshake.
// Build option: define MU0_ILLEGAL_TRAP_EN to halt on opcodes 8-F; otherwise they retire as NOPs.
module mu0_ctrl_seq #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic [3:0]       F,
  input  logic             N,
  input  logic             Z,
  input  logic             MemRdy,
  output logic             MemReq,
  output logic             Rd,
  output logic             Wr,
  output logic             Addr_sel,
  output logic             X_sel,
  output logic             Y_sel,
  output logic [1:0]       M,
  output logic             PC_En,
  output logic             IR_En,
  output logic             Acc_En,
  output logic             Halted,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetCnt
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             retire;
  logic             done;
  logic             jump;
  logic             mem_req, rd, wr, addr_sel, x_sel, y_sel;
  logic [1:0]       m;
  logic             pc_en, ir_en, acc_en, halted;
`ifdef MU0_ILLEGAL_TRAP_EN
  logic             trap;
  logic             illegal_reg;
`endif

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    done       = 1'b0;
    jump       = 1'b0;
    mem_req    = 1'b0;
    rd         = 1'b0;
    wr         = 1'b0;
    addr_sel   = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    m          = 2'b00;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    acc_en     = 1'b0;
    halted     = 1'b0;
`ifdef MU0_ILLEGAL_TRAP_EN
    trap       = 1'b0;
`endif
    case (state_reg)
      FETCH: begin
        mem_req = 1'b1;
        rd      = 1'b1;
        if (MemRdy) begin
          ir_en      = 1'b1;
          pc_en      = 1'b1;
          m          = 2'b10;
          state_next = EXEC;
        end
      end
      EXEC: begin
        case (F)
          4'h0: begin
            mem_req  = 1'b1;
            rd       = 1'b1;
            addr_sel = 1'b1;
            if (MemRdy) begin
              acc_en = 1'b1;
              done   = 1'b1;
            end
          end
          4'h1: begin
            mem_req  = 1'b1;
            wr       = 1'b1;
            addr_sel = 1'b1;
            done     = MemRdy;
          end
          4'h2, 4'h3: begin
            mem_req  = 1'b1;
            rd       = 1'b1;
            addr_sel = 1'b1;
            if (MemRdy) begin
              x_sel  = 1'b1;
              m      = (F == 4'h2) ? 2'b01 : 2'b11;
              acc_en = 1'b1;
              done   = 1'b1;
            end
          end
          4'h4: begin
            jump = 1'b1;
            done = 1'b1;
          end
          4'h5: begin
            jump = !N;
            done = 1'b1;
          end
          4'h6: begin
            jump = !Z;
            done = 1'b1;
          end
          4'h7: begin
            retire     = 1'b1;
            state_next = HALT;
          end
          default: begin
`ifdef MU0_ILLEGAL_TRAP_EN
            trap       = 1'b1;
            state_next = HALT;
`else
            done = 1'b1;
`endif
          end
        endcase
        // Branch target comes straight from IR[11:0] through the ALU pass-Y path.
        if (jump) begin
          y_sel = 1'b1;
          m     = 2'b00;
          pc_en = 1'b1;
        end
        if (done) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      HALT: halted = 1'b1;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state_reg <= FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (retire && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

`ifdef MU0_ILLEGAL_TRAP_EN
  always_ff @(posedge Clk) begin
    if (!nReset)
      illegal_reg <= 1'b0;
    else if (trap)
      illegal_reg <= 1'b1;
  end
  assign Illegal = nReset & illegal_reg;
`else
  assign Illegal = 1'b0;
`endif

  // Reset overrides everything combinationally so the datapath sees idle strobes at once.
  assign MemReq   = nReset & mem_req;
  assign Rd       = nReset & rd;
  assign Wr       = nReset & wr;
  assign Addr_sel = nReset & addr_sel;
  assign X_sel    = nReset & x_sel;
  assign Y_sel    = nReset & y_sel;
  assign M        = nReset ? m : 2'b00;
  assign PC_En    = nReset & pc_en;
  assign IR_En    = nReset & ir_en;
  assign Acc_En   = nReset & acc_en;
  assign Halted   = nReset & halted;
  assign RetCnt   = nReset ? cnt_reg : '0;

endmodule

// File: tb/tb_mu0_ctrl_seq.sv
// Directed bench for mu0_ctrl_seq: one default instance plus a 2-bit counter instance.
module tb_mu0_ctrl_seq;
  logic        clk = 1'b0;
  logic        n_reset, n, z, mem_rdy;
  logic [3:0]  f;
  logic        mem_req, rd, wr, addr_sel, x_sel, y_sel, pc_en, ir_en, acc_en, halted, illegal;
  logic [1:0]  m;
  logic [15:0] ret_cnt;
  logic        s_mem_req, s_rd, s_wr, s_addr_sel, s_x_sel, s_y_sel, s_pc_en, s_ir_en, s_acc_en;
  logic        s_halted, s_illegal;
  logic [1:0]  s_m;
  logic [1:0]  s_ret_cnt;
  logic [12:0] outs;
  int          n_cmp = 0;
  int          n_err = 0;

  // Bit order: MemReq Rd Wr Addr_sel X_sel Y_sel M[1:0] PC_En IR_En Acc_En Halted Illegal
  localparam logic [12:0] ZERO     = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] FETCH_W  = 13'b1_1_0_0_0_0_00_0_0_0_0_0;
  localparam logic [12:0] FETCH_R  = 13'b1_1_0_0_0_0_10_1_1_0_0_0;
  localparam logic [12:0] RD_WAIT  = 13'b1_1_0_1_0_0_00_0_0_0_0_0;
  localparam logic [12:0] LDA_R    = 13'b1_1_0_1_0_0_00_0_0_1_0_0;
  localparam logic [12:0] ADD_R    = 13'b1_1_0_1_1_0_01_0_0_1_0_0;
  localparam logic [12:0] SUB_R    = 13'b1_1_0_1_1_0_11_0_0_1_0_0;
  localparam logic [12:0] STA_R    = 13'b1_0_1_1_0_0_00_0_0_0_0_0;
  localparam logic [12:0] JMP_X    = 13'b0_0_0_0_0_1_00_1_0_0_0_0;
  localparam logic [12:0] HALT_O   = 13'b0_0_0_0_0_0_00_0_0_0_1_0;
  localparam logic [12:0] HALT_ILL = 13'b0_0_0_0_0_0_00_0_0_0_1_1;

  mu0_ctrl_seq u_dut (
    .Clk(clk), .nReset(n_reset), .F(f), .N(n), .Z(z), .MemRdy(mem_rdy),
    .MemReq(mem_req), .Rd(rd), .Wr(wr), .Addr_sel(addr_sel), .X_sel(x_sel), .Y_sel(y_sel),
    .M(m), .PC_En(pc_en), .IR_En(ir_en), .Acc_En(acc_en), .Halted(halted),
    .Illegal(illegal), .RetCnt(ret_cnt)
  );

  mu0_ctrl_seq #(.CNT_W(2)) u_sat (
    .Clk(clk), .nReset(n_reset), .F(f), .N(n), .Z(z), .MemRdy(mem_rdy),
    .MemReq(s_mem_req), .Rd(s_rd), .Wr(s_wr), .Addr_sel(s_addr_sel), .X_sel(s_x_sel),
    .Y_sel(s_y_sel), .M(s_m), .PC_En(s_pc_en), .IR_En(s_ir_en), .Acc_En(s_acc_en),
    .Halted(s_halted), .Illegal(s_illegal), .RetCnt(s_ret_cnt)
  );

  assign outs = {mem_req, rd, wr, addr_sel, x_sel, y_sel, m, pc_en, ir_en, acc_en, halted, illegal};

  always #5 clk = ~clk;

  task automatic cyc(input logic rst_n, input logic [3:0] op, input logic nf, input logic zf,
                     input logic rdy);
    @(negedge clk);
    n_reset = rst_n;
    f       = op;
    n       = nf;
    z       = zf;
    mem_rdy = rdy;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_sat[5] = '{0, 1, 2, 3, 3};
    n_reset = 1'b0; f = 4'h0; n = 1'b0; z = 1'b0; mem_rdy = 1'b0;

    // Power-up reset
    cyc(0, 4'h0, 0, 0, 0); chk("rst0_outs", 32'(outs), 32'(ZERO)); chk("rst0_cnt", 32'(ret_cnt), 0);
    cyc(0, 4'h0, 0, 0, 0); chk("rst1_outs", 32'(outs), 32'(ZERO));

    // Fetch LDA, stall in EXEC, then reset for 2 cycles mid-EXEC
    cyc(1, 4'h0, 0, 0, 1); chk("pre_fetch", 32'(outs), 32'(FETCH_R));
    cyc(1, 4'h0, 0, 0, 0); chk("lda_wait", 32'(outs), 32'(RD_WAIT));
    cyc(0, 4'h0, 0, 0, 0); chk("mid_rst0", 32'(outs), 32'(ZERO));
    cyc(0, 4'h0, 0, 0, 1); chk("mid_rst1", 32'(outs), 32'(ZERO)); chk("mid_rst_cnt", 32'(ret_cnt), 0);
    cyc(1, 4'h0, 0, 0, 0); chk("post_rst_fetch", 32'(outs), 32'(FETCH_W));
    chk("post_rst_cnt", 32'(ret_cnt), 0);

    // Zero-wait program LDA; ADD; STA; STP
    cyc(1, 4'h0, 0, 0, 1); chk("p_fetch_lda", 32'(outs), 32'(FETCH_R));
    cyc(1, 4'h0, 0, 0, 1); chk("p_exec_lda", 32'(outs), 32'(LDA_R));
    cyc(1, 4'h2, 0, 0, 1); chk("p_fetch_add", 32'(outs), 32'(FETCH_R)); chk("p_cnt1", 32'(ret_cnt), 1);
    cyc(1, 4'h2, 0, 0, 1); chk("p_exec_add", 32'(outs), 32'(ADD_R));
    cyc(1, 4'h1, 0, 0, 1); chk("p_fetch_sta", 32'(outs), 32'(FETCH_R)); chk("p_cnt2", 32'(ret_cnt), 2);
    cyc(1, 4'h1, 0, 0, 1); chk("p_exec_sta", 32'(outs), 32'(STA_R));
    cyc(1, 4'h7, 0, 0, 1); chk("p_fetch_stp", 32'(outs), 32'(FETCH_R)); chk("p_cnt3", 32'(ret_cnt), 3);
    cyc(1, 4'h7, 0, 0, 1); chk("p_exec_stp", 32'(outs), 32'(ZERO));
    cyc(1, 4'h7, 0, 0, 1); chk("p_halted", 32'(outs), 32'(HALT_O)); chk("p_cnt4", 32'(ret_cnt), 4);
    cyc(1, 4'h0, 0, 0, 1); chk("p_halt_hold", 32'(outs), 32'(HALT_O)); chk("p_cnt_hold", 32'(ret_cnt), 4);

    // Reset out of HALT
    cyc(0, 4'h0, 0, 0, 1); chk("halt_rst", 32'(outs), 32'(ZERO)); chk("halt_rst_cnt", 32'(ret_cnt), 0);

    // 3-wait fetch of JMP
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'h4, 0, 0, 0); chk($sformatf("wfetch_%0d", i), 32'(outs), 32'(FETCH_W));
    end
    cyc(1, 4'h4, 0, 0, 1); chk("wfetch_done", 32'(outs), 32'(FETCH_R));
    cyc(1, 4'h4, 0, 0, 1); chk("jmp_exec", 32'(outs), 32'(JMP_X));

    // Conditional jumps
    cyc(1, 4'h5, 0, 0, 1); chk("jge_fetch", 32'(outs), 32'(FETCH_R)); chk("j_cnt1", 32'(ret_cnt), 1);
    cyc(1, 4'h5, 1, 0, 1); chk("jge_n1", 32'(outs), 32'(ZERO));
    cyc(1, 4'h5, 0, 0, 1); chk("j_cnt2", 32'(ret_cnt), 2);
    cyc(1, 4'h5, 0, 0, 1); chk("jge_n0", 32'(outs), 32'(JMP_X));
    cyc(1, 4'h6, 0, 1, 1); chk("j_cnt3", 32'(ret_cnt), 3);
    cyc(1, 4'h6, 0, 1, 1); chk("jne_z1", 32'(outs), 32'(ZERO));
    cyc(1, 4'h6, 0, 0, 1); chk("j_cnt4", 32'(ret_cnt), 4);
    cyc(1, 4'h6, 0, 0, 1); chk("jne_z0", 32'(outs), 32'(JMP_X));

    // SUB with one wait state in EXEC
    cyc(1, 4'h3, 0, 0, 1); chk("sub_fetch", 32'(outs), 32'(FETCH_R)); chk("j_cnt5", 32'(ret_cnt), 5);
    cyc(1, 4'h3, 0, 0, 0); chk("sub_wait", 32'(outs), 32'(RD_WAIT));
    cyc(1, 4'h3, 0, 0, 1); chk("sub_exec", 32'(outs), 32'(SUB_R));

    // Undefined opcode 4'hA
    cyc(1, 4'hA, 0, 0, 1); chk("ill_fetch", 32'(outs), 32'(FETCH_R)); chk("ill_cnt0", 32'(ret_cnt), 6);
    cyc(1, 4'hA, 0, 0, 1); chk("ill_exec", 32'(outs), 32'(ZERO));
    cyc(1, 4'hA, 0, 0, 0);
`ifdef MU0_ILLEGAL_TRAP_EN
    chk("ill_trap", 32'(outs), 32'(HALT_ILL)); chk("ill_cnt", 32'(ret_cnt), 6);
`else
    chk("ill_nop", 32'(outs), 32'(FETCH_W)); chk("ill_cnt", 32'(ret_cnt), 7);
`endif
    cyc(0, 4'h0, 0, 0, 0); chk("ill_rst", 32'(outs), 32'(ZERO));

    // Five JMPs: 2-bit counter saturates, 16-bit counter keeps counting
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'h4, 0, 0, 1);
      chk($sformatf("sat_fetch_%0d", i), 32'(outs), 32'(FETCH_R));
      chk($sformatf("sat_cnt2_%0d", i), 32'(s_ret_cnt), 32'(exp_sat[i]));
      chk($sformatf("sat_cnt16_%0d", i), 32'(ret_cnt), 32'(i));
      cyc(1, 4'h4, 0, 0, 1);
      chk($sformatf("sat_jmp_%0d", i), 32'(outs), 32'(JMP_X));
    end
    cyc(1, 4'h4, 0, 0, 0);
    chk("sat_cnt2_final", 32'(s_ret_cnt), 3);
    chk("sat_cnt16_final", 32'(ret_cnt), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
